// File: rtl/presence_tracker.sv
// presence_tracker: multi-channel object presence tracking.
// Each channel needs ACQUIRE_CYCLES consecutive detect samples before it
// declares an object on screen. It then holds on_screen for HOLD_CYCLES
// after detection drops, and emits one-cycle acquire/lost event pulses.
// Optional build macro PRESENCE_COUNT_EN adds the on_count output, which is
// the population count of on_screen.
module presence_tracker #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CLK_FREQ_MHZ   = 50,
  parameter int unsigned HOLD_MS        = 1000,
  parameter int unsigned ACQUIRE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             det,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             on_screen,
  output logic                          any_on_screen,
  output logic [NUM_CH-1:0]             acquired_pulse,
  output logic [NUM_CH-1:0]             lost_pulse
`ifdef PRESENCE_COUNT_EN
  ,
  output logic [$clog2(NUM_CH+1)-1:0]   on_count
`endif
);

  localparam int unsigned HOLD_CYCLES = CLK_FREQ_MHZ * 1000 * HOLD_MS;
  localparam int unsigned CNT_MAX     = (HOLD_CYCLES > ACQUIRE_CYCLES) ? HOLD_CYCLES
                                                                       : ACQUIRE_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state_q [NUM_CH];
  state_t             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_inc [NUM_CH];
  logic [NUM_CH-1:0]  on_screen_d;
  logic [NUM_CH-1:0]  acquired_d;
  logic [NUM_CH-1:0]  lost_d;

  // Next-state, next-count and next-output decode for every channel
  always_comb begin
    on_screen_d = '0;
    acquired_d  = '0;
    lost_d      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = cnt_q[i] + CNT_W'(1);

      if (!ch_en[i]) begin
        // disabled channel is forced idle silently, ahead of detection
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (det[i]) begin
              if (ACQUIRE_CYCLES == 1) begin
                state_d[i] = ST_TRACK;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = ST_ACQ;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          ST_ACQ: begin
            if (!det[i]) begin
              // no partial credit survives a dropout
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_inc[i] == CNT_W'(ACQUIRE_CYCLES)) begin
              state_d[i] = ST_TRACK;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_inc[i];
            end
          end
          ST_TRACK: begin
            if (!det[i]) begin
              if (HOLD_CYCLES == 1) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                lost_d[i]  = 1'b1;
              end else begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          ST_HOLD: begin
            if (det[i]) begin
              // retrigger; the next loss restarts the full hold window
              state_d[i] = ST_TRACK;
              cnt_d[i]   = '0;
            end else if (cnt_inc[i] == CNT_W'(HOLD_CYCLES)) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
              lost_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_inc[i];
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end

      on_screen_d[i] = (state_d[i] == ST_TRACK) || (state_d[i] == ST_HOLD);
      acquired_d[i]  = on_screen_d[i] && !on_screen[i];
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      on_screen      <= '0;
      acquired_pulse <= '0;
      lost_pulse     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      on_screen      <= on_screen_d;
      acquired_pulse <= acquired_d;
      lost_pulse     <= lost_d;
    end
  end

  // Aggregate presence flag, same cycle as on_screen
  always_comb begin
    any_on_screen = |on_screen;
  end

`ifdef PRESENCE_COUNT_EN
  localparam int unsigned OC_W = $clog2(NUM_CH + 1);

  // Number of channels currently on screen
  always_comb begin
    on_count = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      on_count = on_count + OC_W'(on_screen[i]);
    end
  end
`endif

endmodule
